// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR seed generator.
// Optional build macro: LFSR_ZERO_GUARD_EN (escape from the all-zero lockup).
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          LFSR_W_DEF = 16;
    localparam logic [15:0] TAPS_DEF   = 16'hB400;
    localparam logic [15:0] SEED_DEF   = 16'hACE1;

endpackage

// File: rtl/lfsr_seed_gen_if.sv
// Controller <-> seed generator bundle.
// master = game controller FSM, slave = seed generator.
interface lfsr_seed_gen_if #(
    parameter int WIDTH = 64
);
    logic             lfsr_rst;
    logic             en;
    logic [WIDTH-1:0] seed;
    logic             lfsr_load;
    logic             busy;

    modport master (
        output lfsr_rst,
        output en,
        input  seed,
        input  lfsr_load,
        input  busy
    );

    modport slave (
        input  lfsr_rst,
        input  en,
        output seed,
        output lfsr_load,
        output busy
    );
endinterface

// File: rtl/lfsr_core.sv
// Right-shifting Galois LFSR with SEED reload and optional zero guard.
// Optional build macro: LFSR_ZERO_GUARD_EN.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int                 LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0]  TAPS   = TAPS_DEF,
    parameter logic [LFSR_W-1:0]  SEED   = SEED_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init_i,
    input  logic step_i,
    output logic bit_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] cur;

    always_comb begin
        cur = lfsr_q;
`ifdef LFSR_ZERO_GUARD_EN
        // A zero state steps as if it were 1, so it can never stick.
        if (lfsr_q == '0) cur = LFSR_W'(1);
`endif
        lfsr_d = lfsr_q;
        if (init_i)
            lfsr_d = SEED;
        else if (step_i)
            lfsr_d = (cur >> 1) ^ (cur[0] ? TAPS : '0);
    end

    assign bit_o = cur[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/lfsr_seed_gen.sv
// Seed generator: FSM, bit counter and seed shift register around lfsr_core.
// Optional build macro: LFSR_ZERO_GUARD_EN (passed through to lfsr_core).
module lfsr_seed_gen
    import lfsr_pkg::*;
#(
    parameter int                WIDTH  = 64,
    parameter int                LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS   = TAPS_DEF,
    parameter logic [LFSR_W-1:0] SEED   = SEED_DEF
) (
    input  logic             clk,
    input  logic             reset,
    lfsr_seed_gen_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   seed_q, seed_d;
    logic               step;
    logic               init;
    logic               b;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_core (
        .clk    (clk),
        .rst_n  (reset),
        .init_i (init),
        .step_i (step),
        .bit_o  (b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        step    = 1'b0;
        init    = 1'b0;
        if (bus.lfsr_rst) begin
            init    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            seed_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        step    = 1'b1;
                        seed_d  = {seed_q[WIDTH-2:0], b};
                        cnt_d   = CNT_W'(1);
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (bus.en) begin
                        step   = 1'b1;
                        seed_d = {seed_q[WIDTH-2:0], b};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(WIDTH))
                            state_d = DONE;
                    end
                end
                DONE: begin
                    // Controller must drop en for an edge to ask again.
                    if (!bus.en) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.lfsr_load = 1'b0;
        bus.busy      = 1'b0;
        unique case (1'b1)
            (state_q == DONE): bus.lfsr_load = 1'b1;
            (state_q == FILL): bus.busy      = 1'b1;
            default: ;
        endcase
    end

    assign bus.seed = seed_q;

endmodule
